// File: rtl/arb_mux_rr.sv
// Arbitrated CH:1 registered mux with valid/ready handshakes.
// Round-robin or fixed-priority grant feeding a single-entry output register.
module arb_mux_rr #(
  parameter int N  = 32,
  parameter int CH = 4,
  localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*N-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  input  logic            mode,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          gnt_any;
  logic [SW-1:0] gnt_idx;
  logic          can_accept;
  logic          take;

  // Lowest valid index overall, then overridden by the lowest
  // valid index at or above ptr when round-robin is active.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(i);
      end
    end
    if (!mode) begin
      for (int i = CH - 1; i >= 0; i--) begin
        if (in_valid[i] && (SW'(i) >= ptr_q)) begin
          gnt_idx = SW'(i);
        end
      end
    end
  end

  assign can_accept = !out_valid_q || out_ready;
  assign take       = gnt_any && can_accept && !rst;

  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[gnt_idx*N +: N];
      out_sel_d   = gnt_idx;
      if (!mode) begin
        ptr_d = (gnt_idx == SW'(CH - 1)) ? '0 : gnt_idx + SW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed bench for arb_mux_rr: a CH=4 and a CH=3 instance.
// Inputs change #1 after posedge; outputs are compared before the next edge.
module tb_arb_mux_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         mode;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  logic [2:0]   in_valid3;
  logic [95:0]  in_data3;
  logic [2:0]   in_ready3;
  logic         out_valid3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_mux_rr #(.N(32), .CH(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode),
    .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  arb_mux_rr #(.N(32), .CH(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .mode(1'b0),
    .out_valid(out_valid3), .out_data(out_data3),
    .out_sel(out_sel3), .out_ready(1'b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++)
      in_data[i*32 +: 32] = 32'h1000_0000 + i;
    for (int i = 0; i < 3; i++)
      in_data3[i*32 +: 32] = 32'h3000_0000 + i;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_valid3 = '0;
    mode = 1'b0;
    out_ready = 1'b1;
    set_data();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; out_ready = 1'b1;
    in_valid = 4'b1111; in_valid3 = '0;
    set_data();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rst_in_ready cyc%0d got %b exp 0000", c, in_ready);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL rst_out got v%b d%h s%0d exp v0 d0 s0", out_valid, out_data, out_sel);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_first_grant got %b exp 0001", in_ready);
    end
    tick();
    // Load ptr away from 0, then reset with a live handshake.
    in_valid = 4'b0100;
    tick();
    rst = 1'b1;
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_in_ready got %b exp 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_out got v%b d%h exp v0 d0", out_valid, out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr got %b exp 0001", in_ready);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    in_data[64 +: 32] = 32'hDEADBEEF;
    in_valid = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready got %b exp 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_sel !== 2'd2) begin
      errors++;
      $display("FAIL single_out got v%b d%h s%0d exp v1 dDEADBEEF s2", out_valid, out_data, out_sel);
    end
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL single_next got %b exp 1000", in_ready);
    end
    tick();
    checks++;
    if (out_sel !== 2'd3 || out_data !== 32'h1000_0003) begin
      errors++;
      $display("FAIL single_next_out got s%0d d%h exp s3 d10000003", out_sel, out_data);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] oh;
    do_reset();
    in_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      oh = 4'b0001 << seq[c];
      #1;
      checks++;
      if (in_ready !== oh) begin
        errors++;
        $display("FAIL rr_ready cyc%0d got %b exp %b", c, in_ready, oh);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== seq[c] || out_data !== 32'h1000_0000 + 32'(seq[c])) begin
        errors++;
        $display("FAIL rr_out cyc%0d got v%b s%0d d%h exp v1 s%0d", c, out_valid, out_sel, out_data, seq[c]);
      end
    end
  endtask

  task automatic test_fixed_mode_switch();
    do_reset();
    in_valid = 4'b0010;
    tick();
    mode = 1'b1;
    in_valid = 4'b1110;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1) begin
        errors++;
        $display("FAIL fixed_sel cyc%0d got v%b s%0d exp v1 s1", c, out_valid, out_sel);
      end
    end
    mode = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL switch_ready got %b exp 0100", in_ready);
    end
    tick();
    checks++;
    if (out_sel !== 2'd2) begin
      errors++;
      $display("FAIL switch_sel got %0d exp 2", out_sel);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data[31:0] = 32'hA5A5A5A5;
    in_valid = 4'b0001;
    tick();
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready cyc%0d got %b exp 0000", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || out_sel !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got v%b d%h s%0d exp v1 dA5A5A5A5 s0", c, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release got %b exp 0010", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1000_0001 || out_sel !== 2'd1) begin
      errors++;
      $display("FAIL bp_next got v%b d%h s%0d exp v1 d10000001 s1", out_valid, out_data, out_sel);
    end
    in_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h1000_0001 || out_sel !== 2'd1) begin
      errors++;
      $display("FAIL drain got v%b d%h s%0d exp v0 d10000001 s1", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_npot();
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    do_reset();
    in_valid3 = 3'b111;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_valid3 !== 1'b1 || out_sel3 !== seq[c] || out_data3 !== 32'h3000_0000 + 32'(seq[c])) begin
        errors++;
        $display("FAIL npot cyc%0d got v%b s%0d d%h exp v1 s%0d", c, out_valid3, out_sel3, out_data3, seq[c]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_valid3 = '0;
    in_data = '0;
    in_data3 = '0;
    mode = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_mode_switch();
    test_backpressure();
    test_npot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux_rr.md
# arb_mux_rr

Parametrised CH-input, N-bit registered multiplexer with valid/ready handshakes and built-in arbitration. It replaces the static 2:1 select used on datapath buses where several requesters share one consumer, such as instruction/data ports to a shared memory or multiple writeback sources. Instead of an external control bit, it picks one valid requester per cycle, either round-robin or fixed-priority. The selected word goes through a single-entry output register at full throughput.

## Interface
- N, 32, data width per channel
- CH, 4, number of input channels, legal range 2..16, need not be a power of two
- SW, derived localparam = max(1, $clog2(CH)), width of channel index; not overridable

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  CH  per-channel request; bit i belongs to channel i
- in_data  in  CH*N  channel i word at [i*N +: N]
- in_ready  out  CH  one-hot or zero; channel i word is taken on a clock edge where in_valid[i] & in_ready[i]
- mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- out_valid  out  1  output register holds a word
- out_data  out  N  held word
- out_sel  out  SW  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts out_data on an edge where out_valid & out_ready

## Operation
- State consists of:
  - output register {out_valid, out_data, out_sel};
  - round-robin pointer ptr (SW bits, range 0..CH-1), the highest-priority channel index.
- can_accept = !out_valid | out_ready (register empty, or draining this cycle).
- Arbitration is combinational each cycle and uses in_valid, ptr and mode:
  - mode=0: the winner g is the first i with in_valid[i] set, scanning ptr, ptr+1, … with wrap at CH-1 → 0.
  - mode=1: the winner g is the lowest index i with in_valid[i] set; ptr is ignored.
- in_ready[g] = can_accept & !rst. All other in_ready bits are 0. If no in_valid bit is set, in_ready = 0.
- in_ready depends combinationally on in_valid. Requesters must not make in_valid depend on in_ready.
- On an accept (any in_valid[g] & in_ready[g]):
  - out_data <= word of channel g; out_sel <= g; out_valid <= 1.
  - mode=0 only: ptr <= (g == CH-1) ? 0 : g+1.
  - mode=1: ptr unchanged.
- On a drain without accept (out_valid & out_ready, no winner): out_valid <= 0. out_data and out_sel hold their last values.
- While out_valid & !out_ready, out_data and out_sel are stable and in_ready = 0.
- A mode change applies to the arbitration of the same cycle. ptr is retained across mode changes.
- Winner computation is at most CH-deep priority logic. No arithmetic beyond the ptr increment with explicit wrap; this increment must be correct for non-power-of-two CH.
- A requester that drops in_valid before it is granted is simply skipped. The block does not track or lock pending requests.

## Timing
- Reset, checked at the first edge with rst=1: out_valid=0, out_data=0, out_sel=0, ptr=0.
- in_ready is 0 in any cycle with rst=1.
- Reset mid-operation discards any held word. Any handshake presented in the rst cycle is not taken.
- Latency: an input accepted at edge k appears on out_data/out_valid after edge k, with out_valid=1 in cycle k+1.
- Throughput: one word per cycle when out_ready is held at 1. Simultaneous drain and accept in the same cycle is required and must leave no bubble.
- Fairness: with mode=0 and every channel continuously valid, each channel is granted exactly once every CH accepts.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles, in_valid=4'b1111, out_ready=1.
  - Required response: in_ready=0 in both cycles. Then out_valid=0, out_data=0, out_sel=0. The first grant after release is channel 0.
- Single request:
  - Stimulus: CH=4, N=32, mode=0, in_valid=4'b0100, channel 2 data=32'hDEADBEEF, out_ready=1.
  - Required response: in_ready=4'b0100 in the same cycle. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=2. The following grant with all channels valid is channel 3.
- Round-robin:
  - Stimulus: mode=0, in_valid=4'b1111 with channel i data = 32'h1000_0000+i, out_ready=1 for 6 cycles.
  - Required response: out_sel sequence 0,1,2,3,0,1, one word per cycle with no bubbles.
- Fixed priority and mode switch:
  - Stimulus: mode=1, in_valid=4'b1110, 3 cycles; then mode=0.
  - Required response: out_sel=1,1,1. After the switch, grants follow the retained ptr, giving 2 if ptr was 2.
- Backpressure:
  - Stimulus: fill the register with 32'hA5A5A5A5 from channel 0, then out_ready=0 for 3 cycles with in_valid=4'b1111.
  - Required response: in_ready=0, and out_data/out_sel are stable for 3 cycles. When out_ready=1, the word drains and the next winner is accepted in the same cycle.
- Non-power-of-two:
  - Stimulus: CH=3, mode=0, all valid, out_ready=1.
  - Required response: out_sel=0,1,2,0,1. ptr never takes the value 3.
